hit_arbiter: RTL and testbench

HIT_ARBITER -- requirements
Module: hit_arbiter

---
 rtl/wam_pkg.sv | 11 +
 rtl/wam_sat_counter.sv | 21 ++
 rtl/hit_arbiter.sv | 113 +++++++++++
 tb/tb_hit_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// wam_pkg: shared state encoding, widths and the starting-lives clamp for hit_arbiter.
package wam_pkg;
   localparam int SCORE_W   = 6;
   localparam int LIVES_W   = 4;
   localparam int MAX_LIVES = 9;
   localparam int POS_W     = 4;
   typedef enum logic [2:0] {IDLE, WAIT_LIGHT, WINDOW, LOCKED, OVER} state_t;
   function automatic logic [LIVES_W-1:0] clamp_lives(input logic [LIVES_W-1:0] v);
      return (v == '0) ? LIVES_W'(1) : ((32'(v) > MAX_LIVES) ? LIVES_W'(MAX_LIVES) : v);
   endfunction
endpackage

// File: rtl/wam_sat_counter.sv
// wam_sat_counter: loadable up/down counter that saturates at 0 and at MAX.
module wam_sat_counter #(
   parameter int W = 6,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_inc,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_cnt <= '0;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_inc && !i_dec && r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
      else if (i_dec && !i_inc && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_cnt = r_cnt;
endmodule

// File: rtl/hit_arbiter.sv
// hit_arbiter: whack-a-mole judge; scores keys against the lit position, tracks lives and rounds.
// Define WAM_TIMEOUT_MISS_EN to count a light that expires unhit as a miss.
module hit_arbiter
   import wam_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                run,
   input  logic                use_points,
   input  logic                use_lives,
   input  logic [SCORE_W-1:0]  max_hits,
   input  logic [LIVES_W-1:0]  lives_init,
   input  logic                light_valid,
   input  logic [POS_W-1:0]    light_pos,
   input  logic                key_valid,
   input  logic [POS_W-1:0]    key,
   output logic [SCORE_W-1:0]  score,
   output logic [LIVES_W-1:0]  lives_left,
   output logic [SCORE_W-1:0]  rounds,
   output logic                hit,
   output logic                miss,
   output logic                window_open,
   output logic                game_over
);
   state_t             r_state, w_next;
   logic [POS_W-1:0]   r_pos;
   logic               r_hit, r_miss, r_window_open, r_game_over;
   logic               w_hit, w_miss, w_score_inc, w_rounds_inc, w_lives_dec, w_latch;
   logic               w_at_limit;

   assign w_at_limit = use_points && (rounds == max_hits);

   // A key in WINDOW is judged against the old position before any same-cycle light relatches it.
   always_comb begin
      w_next       = r_state;
      w_hit        = 1'b0;
      w_miss       = 1'b0;
      w_score_inc  = 1'b0;
      w_rounds_inc = 1'b0;
      w_lives_dec  = 1'b0;
      w_latch      = 1'b0;
      if (start) w_next = IDLE;
      else begin
         case (r_state)
            IDLE: w_next = run ? WAIT_LIGHT : IDLE;
            OVER: w_next = OVER;
            default: begin
               if (!run) w_next = IDLE;
               else if (use_lives && lives_left == '0) w_next = OVER;
               else begin
                  if (r_state == WINDOW && key_valid) begin
                     w_hit       = (key == r_pos);
                     w_miss      = !w_hit;
                     w_score_inc = w_hit;
                     w_lives_dec = w_miss && use_lives;
                     w_next      = LOCKED;
                  end
`ifdef WAM_TIMEOUT_MISS_EN
                  else if (r_state == WINDOW && light_valid) begin
                     w_miss      = 1'b1;
                     w_lives_dec = use_lives;
                  end
`endif
                  if (light_valid) begin
                     w_latch      = !w_at_limit;
                     w_rounds_inc = !w_at_limit;
                     w_next       = w_at_limit ? OVER : WINDOW;
                  end
                  if (r_state == WINDOW && key_valid && w_at_limit) w_next = OVER;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state       <= IDLE;
         r_pos         <= '0;
         r_hit         <= 1'b0;
         r_miss        <= 1'b0;
         r_window_open <= 1'b0;
         r_game_over   <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_pos         <= w_latch ? light_pos : r_pos;
         r_hit         <= w_hit;
         r_miss        <= w_miss;
         r_window_open <= (w_next == WINDOW);
         r_game_over   <= (w_next == OVER);
      end

   assign hit         = r_hit;
   assign miss        = r_miss;
   assign window_open = r_window_open;
   assign game_over   = r_game_over;

   wam_sat_counter #(.W(SCORE_W)) u_score (
      .clk(clk), .reset(reset), .i_load(start), .i_load_val('0),
      .i_inc(w_score_inc), .i_dec(1'b0), .o_cnt(score)
   );

   wam_sat_counter #(.W(SCORE_W)) u_rounds (
      .clk(clk), .reset(reset), .i_load(start), .i_load_val('0),
      .i_inc(w_rounds_inc), .i_dec(1'b0), .o_cnt(rounds)
   );

   wam_sat_counter #(.W(LIVES_W), .MAX(LIVES_W'(MAX_LIVES))) u_lives (
      .clk(clk), .reset(reset), .i_load(start), .i_load_val(clamp_lives(lives_init)),
      .i_inc(1'b0), .i_dec(w_lives_dec), .o_cnt(lives_left)
   );
endmodule

// File: tb/tb_hit_arbiter.sv
// tb_hit_arbiter: directed vectors with hand-computed expectations for hit_arbiter.
module tb_hit_arbiter;
   logic       clk = 1'b0;
   logic       reset, start, run, use_points, use_lives, light_valid, key_valid;
   logic [5:0] max_hits;
   logic [3:0] lives_init, light_pos, key;
   logic [5:0] score, rounds;
   logic [3:0] lives_left;
   logic       hit, miss, window_open, game_over;
   int         n_vec = 0;
   int         n_err = 0;

   hit_arbiter dut (
      .clk(clk), .reset(reset), .start(start), .run(run),
      .use_points(use_points), .use_lives(use_lives),
      .max_hits(max_hits), .lives_init(lives_init),
      .light_valid(light_valid), .light_pos(light_pos),
      .key_valid(key_valid), .key(key),
      .score(score), .lives_left(lives_left), .rounds(rounds),
      .hit(hit), .miss(miss), .window_open(window_open), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [3:0] li);
      lives_init = li;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic light(input logic [3:0] p);
      light_valid = 1'b1;
      light_pos = p;
      step();
      light_valid = 1'b0;
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key = k;
      step();
      key_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; run = 1'b0; use_points = 1'b0; use_lives = 1'b0;
      light_valid = 1'b0; key_valid = 1'b0; max_hits = 6'd0; lives_init = 4'd0;
      light_pos = 4'd0; key = 4'd0;
      step(); step();
      chk("rst_score", score, 0);
      chk("rst_rounds", rounds, 0);
      chk("rst_lives", lives_left, 0);
      chk("rst_flags", {hit, miss, window_open, game_over}, 0);
      reset = 1'b0;
      step();
      // lives clamp on start
      do_start(4'd0);
      chk("clamp_lo", lives_left, 1);
      do_start(4'd12);
      chk("clamp_hi", lives_left, 9);
      chk("start_score", score, 0);
      // basic hit, then a second key is ignored
      run = 1'b1;
      step();
      light(4'd4);
      chk("win_open", window_open, 1);
      chk("rounds1", rounds, 1);
      press(4'd4);
      chk("hit_pulse", {hit, miss}, 2'b10);
      chk("score1", score, 1);
      chk("win_closed", window_open, 0);
      step();
      chk("hit_drop", hit, 0);
      press(4'd4);
      chk("ignored_key", {hit, miss}, 0);
      chk("ignored_score", score, 1);
      // simultaneous key and light in WINDOW
      light(4'd5);
      chk("rounds2", rounds, 2);
      key_valid = 1'b1; key = 4'd5; light_valid = 1'b1; light_pos = 4'd1;
      step();
      key_valid = 1'b0; light_valid = 1'b0;
      chk("simul_hit", {hit, miss}, 2'b10);
      chk("simul_score", score, 2);
      chk("simul_win", window_open, 1);
      chk("simul_rounds", rounds, 3);
      press(4'd1);
      chk("relatch_hit", hit, 1);
      chk("relatch_score", score, 3);
      // run low parks in IDLE and holds counts
      run = 1'b0;
      step();
      light(4'd2);
      chk("idle_rounds", rounds, 3);
      chk("idle_win", window_open, 0);
      chk("idle_score", score, 3);
      // expired light with use_lives
      use_lives = 1'b1;
      do_start(4'd3);
      run = 1'b1;
      step();
      light(4'd0);
      light(4'd3);
`ifdef WAM_TIMEOUT_MISS_EN
      chk("timeout_miss", miss, 1);
      chk("timeout_lives", lives_left, 2);
`else
      chk("timeout_miss", miss, 0);
      chk("timeout_lives", lives_left, 3);
`endif
      chk("timeout_win", window_open, 1);
      chk("timeout_rounds", rounds, 2);
      // last life lost ends the game
      do_start(4'd1);
      step();
      light(4'd2);
      press(4'd7);
      chk("miss_pulse", {hit, miss}, 2'b01);
      chk("lives_zero", lives_left, 0);
      chk("over_not_yet", game_over, 0);
      step();
      chk("over_set", game_over, 1);
      chk("miss_drop", miss, 0);
      press(4'd2);
      light(4'd2);
      chk("over_score", score, 0);
      chk("over_rounds", rounds, 1);
      chk("over_hold", game_over, 1);
      do_start(4'd5);
      chk("restart_over", game_over, 0);
      chk("restart_lives", lives_left, 5);
      // round limit
      use_lives = 1'b0; use_points = 1'b1; max_hits = 6'd3;
      do_start(4'd2);
      step();
      for (int i = 0; i < 3; i++) begin
         light(4'(i + 2));
         press(4'(i + 2));
         chk("limit_hit", hit, 1);
         chk("limit_over", game_over, (i == 2) ? 1 : 0);
      end
      chk("limit_score", score, 3);
      chk("limit_rounds", rounds, 3);
      // reset mid-window discards it
      use_points = 1'b0;
      do_start(4'd4);
      step();
      light(4'd6);
      chk("pre_rst_win", window_open, 1);
      key_valid = 1'b1; key = 4'd6;
      #2 reset = 1'b1;
      #1;
      chk("async_win", window_open, 0);
      chk("async_lives", lives_left, 0);
      step();
      reset = 1'b0; key_valid = 1'b0;
      step();
      chk("rst_no_pulse", {hit, miss}, 0);
      chk("rst_score2", score, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
